// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: walks a table of directed vectors through the core.
// Each vector writes {instr, HALT} to RAM, restarts the core, runs it to HALT or
// timeout, then reads one architectural result back through the debug port and
// compares it against the expected value.
// Ports: clk/reset; start/abort control; vec_* table lookup; mem_* RAM write
// port; cpu_hold/cpu_restart/cpu_halted core control; dbg_* debug read;
// busy/done/pass_count/fail_count/first_fail/any_fail/timeout_seen status.
// Latency: FETCH, WR0, WR1, RESTART, then 1..TIMEOUT RUN cycles, READ, CMP, NEXT
// per vector. No backpressure; abort ends the sequence on the next cycle.

module proc_test_sequencer #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 9,
    parameter int                NUM_TESTS = 16,
    parameter int                IDX_W     = 4,
    parameter int                TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] HALT_WORD = {5'd26, 27'd0}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  vec_idx,
    input  logic [DATA_W-1:0] vec_instr,
    input  logic [1:0]        vec_sel,
    input  logic [ADDR_W-1:0] vec_addr,
    input  logic [DATA_W-1:0] vec_expected,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_restart,
    input  logic              cpu_halted,
    output logic [1:0]        dbg_sel,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    pass_count,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail,
    output logic              any_fail,
    output logic              timeout_seen
);

    // The run counter only has to reach TIMEOUT-1.
    localparam int CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR0, S_WR1, S_RESTART,
        S_RUN, S_READ, S_CMP, S_NEXT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               cpu_restart_q, cpu_restart_d;
    logic [1:0]         dbg_sel_q, dbg_sel_d;
    logic [ADDR_W-1:0]  dbg_addr_q, dbg_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W:0]     pass_q, pass_d;
    logic [IDX_W:0]     fail_q, fail_d;
    logic [IDX_W-1:0]   first_fail_q, first_fail_d;
    logic               any_fail_q, any_fail_d;
    logic               timeout_q, timeout_d;

    // Outputs are registered and computed from the next state, so every output
    // flop reflects the state the machine is actually in during that cycle.
    always_comb begin
        state_d       = state_q;
        vec_idx_d     = vec_idx_q;
        cycle_d       = cycle_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_hold_d    = 1'b1;
        cpu_restart_d = 1'b0;
        dbg_sel_d     = dbg_sel_q;
        dbg_addr_d    = dbg_addr_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        first_fail_d  = first_fail_q;
        any_fail_d    = any_fail_q;
        timeout_d     = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_FETCH;
                    vec_idx_d    = '0;
                    pass_d       = '0;
                    fail_d       = '0;
                    first_fail_d = '0;
                    any_fail_d   = 1'b0;
                    timeout_d    = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            // vec_instr has had a full cycle to settle on the new vec_idx.
            S_FETCH: begin
                state_d     = S_WR0;
                mem_we_d    = 1'b1;
                mem_addr_d  = '0;
                mem_wdata_d = vec_instr;
            end
            S_WR0: begin
                state_d     = S_WR1;
                mem_we_d    = 1'b1;
                mem_addr_d  = ADDR_W'(1);
                mem_wdata_d = HALT_WORD;
            end
            S_WR1: begin
                state_d       = S_RESTART;
                cpu_restart_d = 1'b1;
            end
            // cpu_halted is deliberately not looked at here: it may still be
            // the previous vector's halt, which the restart pulse clears.
            S_RESTART: begin
                state_d    = S_RUN;
                cycle_d    = '0;
                cpu_hold_d = 1'b0;
            end
            S_RUN: begin
                cycle_d = cycle_q + 1'b1;
                if (cpu_halted) begin
                    state_d    = S_READ;
                    dbg_sel_d  = vec_sel;
                    dbg_addr_d = vec_addr;
                end else if (cycle_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = S_NEXT;
                    timeout_d  = 1'b1;
                    fail_d     = fail_q + 1'b1;
                    any_fail_d = 1'b1;
                    if (!any_fail_q) begin
                        first_fail_d = vec_idx_q;
                    end
                end else begin
                    cpu_hold_d = 1'b0;
                end
            end
            // Debug data becomes valid the cycle after dbg_sel/dbg_addr.
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                state_d = S_NEXT;
                if (dbg_rdata == vec_expected) begin
                    pass_d = pass_q + 1'b1;
                end else begin
                    fail_d     = fail_q + 1'b1;
                    any_fail_d = 1'b1;
                    if (!any_fail_q) begin
                        first_fail_d = vec_idx_q;
                    end
                end
            end
            S_NEXT: begin
                if (vec_idx_q == IDX_W'(NUM_TESTS - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = S_FETCH;
                    vec_idx_d = vec_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything above and discards the current vector.
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d       = S_DONE;
            vec_idx_d     = vec_idx_q;
            mem_we_d      = 1'b0;
            cpu_hold_d    = 1'b1;
            cpu_restart_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            pass_d        = pass_q;
            fail_d        = fail_q;
            first_fail_d  = first_fail_q;
            any_fail_d    = any_fail_q;
            timeout_d     = timeout_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vec_idx_q     <= '0;
            cycle_q       <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_hold_q    <= 1'b1;
            cpu_restart_q <= 1'b0;
            dbg_sel_q     <= '0;
            dbg_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= '0;
            fail_q        <= '0;
            first_fail_q  <= '0;
            any_fail_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_idx_q     <= vec_idx_d;
            cycle_q       <= cycle_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_hold_q    <= cpu_hold_d;
            cpu_restart_q <= cpu_restart_d;
            dbg_sel_q     <= dbg_sel_d;
            dbg_addr_q    <= dbg_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            first_fail_q  <= first_fail_d;
            any_fail_q    <= any_fail_d;
            timeout_q     <= timeout_d;
        end
    end

    assign vec_idx      = vec_idx_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign cpu_restart  = cpu_restart_q;
    assign dbg_sel      = dbg_sel_q;
    assign dbg_addr     = dbg_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_count   = pass_q;
    assign fail_count   = fail_q;
    assign first_fail   = first_fail_q;
    assign any_fail     = any_fail_q;
    assign timeout_seen = timeout_q;

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Testbench for proc_test_sequencer with a small stand-in core and RAM.

module tb_proc_test_sequencer;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 9;
    localparam int          NT     = 16;
    localparam int          IDX_W  = 4;
    localparam int          TO     = 64;
    localparam logic [31:0] HALT   = {5'd26, 27'd0};

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [IDX_W-1:0]  vec_idx;
    logic [DATA_W-1:0] vec_instr;
    logic [1:0]        vec_sel;
    logic [ADDR_W-1:0] vec_addr;
    logic [DATA_W-1:0] vec_expected;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              cpu_restart;
    logic              cpu_halted = 1'b0;
    logic [1:0]        dbg_sel;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata = '0;
    logic              busy;
    logic              done;
    logic [IDX_W:0]    pass_count;
    logic [IDX_W:0]    fail_count;
    logic [IDX_W-1:0]  first_fail;
    logic              any_fail;
    logic              timeout_seen;

    always #5 clk = ~clk;

    proc_test_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TESTS(NT), .IDX_W(IDX_W),
        .TIMEOUT(TO), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .vec_idx(vec_idx), .vec_instr(vec_instr), .vec_sel(vec_sel),
        .vec_addr(vec_addr), .vec_expected(vec_expected),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_restart(cpu_restart), .cpu_halted(cpu_halted),
        .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
        .busy(busy), .done(done), .pass_count(pass_count),
        .fail_count(fail_count), .first_fail(first_fail),
        .any_fail(any_fail), .timeout_seen(timeout_seen)
    );

    // Vector table plus the behaviour the stand-in core shows for each vector.
    logic [31:0] instr_tab [NT];
    logic [31:0] exp_tab   [NT];
    logic [31:0] res_tab   [NT];
    logic [1:0]  sel_tab   [NT];
    logic [8:0]  addr_tab  [NT];
    int          delay_tab [NT];   // unheld cycles until HALT; >= TO never halts in time

    assign vec_instr    = instr_tab[vec_idx];
    assign vec_sel      = sel_tab[vec_idx];
    assign vec_addr     = addr_tab[vec_idx];
    assign vec_expected = exp_tab[vec_idx];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Stand-in core: halt stays set until the next restart pulse, so the
    // previous vector's halt is visible during the following FETCH..RESTART.
    logic [31:0] ram [512];
    int          run_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (cpu_restart) begin
            cpu_halted <= 1'b0;
            run_cnt    <= 0;
        end else if (!cpu_hold && !cpu_halted) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt + 1 >= delay_tab[vec_idx]) cpu_halted <= 1'b1;
        end
        dbg_rdata <= (dbg_sel == sel_tab[vec_idx] && dbg_addr == addr_tab[vec_idx])
                     ? res_tab[vec_idx] : ~res_tab[vec_idx];
    end

    // Per-vector monitor: RAM image at restart and length of the run window.
    bit tracking  = 1'b0;
    bit chk_run   = 1'b1;
    int run_cycles = 0;
    always @(negedge clk) begin
        if (reset) begin
            tracking = 1'b0;
        end else if (cpu_restart) begin
            chk("restart_no_we", {31'd0, mem_we}, 32'd0);
            chk("ram0_instr", ram[0], instr_tab[vec_idx]);
            chk("ram1_halt", ram[1], HALT);
            tracking   = 1'b1;
            run_cycles = 0;
        end else if (tracking) begin
            if (!cpu_hold) begin
                run_cycles++;
            end else begin
                if (chk_run)
                    chk("run_cycles", run_cycles,
                        (delay_tab[vec_idx] >= TO) ? TO : delay_tab[vec_idx] + 1);
                tracking = 1'b0;
            end
        end
    end

    // Reference: each vector is a timeout if the core needs >= TO cycles,
    // otherwise it passes iff the read-back result equals the expected value.
    task automatic model(output int p, output int f, output int ff,
                         output int any, output int tos);
        p = 0; f = 0; ff = 0; any = 0; tos = 0;
        for (int i = 0; i < NT; i++) begin
            bit bad;
            bad = 1'b0;
            if (delay_tab[i] >= TO) begin
                tos = 1;
                bad = 1'b1;
            end else if (exp_tab[i] != res_tab[i]) begin
                bad = 1'b1;
            end
            if (bad) begin
                if (any == 0) ff = i;
                any = 1;
                f++;
            end else begin
                p++;
            end
        end
    endtask

    task automatic setup(input logic [15:0] fail_m, input logic [15:0] to_m,
                         input logic [15:0] edge_m);
        for (int i = 0; i < NT; i++) begin
            instr_tab[i] = $urandom;
            sel_tab[i]   = 2'($urandom_range(0, 3));
            addr_tab[i]  = 9'($urandom_range(0, 511));
            res_tab[i]   = $urandom;
            if (edge_m[i])     delay_tab[i] = TO - 1;
            else if (to_m[i])  delay_tab[i] = 1000;
            else               delay_tab[i] = $urandom_range(1, 20);
            exp_tab[i] = fail_m[i] ? (res_tab[i] ^ (32'h1 << $urandom_range(0, 31)))
                                   : res_tab[i];
        end
    endtask

    task automatic run_seq(input string tag, input int ep, input int ef,
                           input int eff, input int eany, input int eto);
        int cyc;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_pass"}, 32'(pass_count), ep);
        chk({tag, "_fail"}, 32'(fail_count), ef);
        chk({tag, "_first"}, 32'(first_fail), eff);
        chk({tag, "_any"}, {31'd0, any_fail}, eany);
        chk({tag, "_tout"}, {31'd0, timeout_seen}, eto);
        chk({tag, "_idle"}, {30'd0, busy, cpu_hold}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] fail_m;
        logic [15:0] to_m;
        logic [15:0] edge_m;
        int          e_pass;
        int          e_fail;
        int          e_ff;
        int          e_any;
        int          e_to;
    } scen_t;

    scen_t tbl [7];

    initial begin
        int cyc, mp, mf, mff, many, mto, we_seen;
        tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 16, 0, 0, 0, 0};
        tbl[1] = '{16'h0004, 16'h0000, 16'h0000, 15, 1, 2, 1, 0};
        tbl[2] = '{16'h0000, 16'h0001, 16'h0000, 15, 1, 0, 1, 1};
        tbl[3] = '{16'h8000, 16'h0100, 16'h0000, 14, 2, 8, 1, 1};
        tbl[4] = '{16'hFFFF, 16'h0000, 16'h0000, 0, 16, 0, 1, 0};
        tbl[5] = '{16'h0001, 16'h0000, 16'h00F0, 15, 1, 0, 1, 0};
        tbl[6] = '{16'h0020, 16'h0060, 16'h0000, 14, 2, 5, 1, 1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        setup(16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_hold_restart_we", {29'd0, cpu_hold, cpu_restart, mem_we}, 32'd4);
        chk("rst_counts", {22'd0, pass_count, fail_count}, 32'd0);
        chk("rst_idx_dbg", {25'd0, vec_idx, dbg_sel, any_fail}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("idle_holds", {30'd0, busy, cpu_hold}, 32'd1);

        for (int s = 0; s < 7; s++) begin
            setup(tbl[s].fail_m, tbl[s].to_m, tbl[s].edge_m);
            run_seq($sformatf("tbl%0d", s), tbl[s].e_pass, tbl[s].e_fail,
                    tbl[s].e_ff, tbl[s].e_any, tbl[s].e_to);
        end

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NT; i++) begin
                instr_tab[i] = $urandom;
                sel_tab[i]   = 2'($urandom_range(0, 3));
                addr_tab[i]  = 9'($urandom_range(0, 511));
                res_tab[i]   = $urandom;
                delay_tab[i] = $urandom_range(1, 72);
                exp_tab[i]   = ($urandom_range(0, 3) == 0) ? res_tab[i] + 32'd1 : res_tab[i];
            end
            model(mp, mf, mff, many, mto);
            run_seq($sformatf("rnd%0d", r), mp, mf, mff, many, mto);
        end

        // Abort while vector 5 is running.
        setup(16'h0, 16'h0, 16'h0);
        for (int i = 0; i < NT; i++) delay_tab[i] = 30;
        chk_run = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(vec_idx == 4'd5 && !cpu_hold) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_run5", {31'd0, (vec_idx == 4'd5 && !cpu_hold)}, 32'd1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_done", {29'd0, done, busy, cpu_hold}, 32'd5);
        chk("abort_count", 32'(pass_count) + 32'(fail_count), 32'd5);
        we_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        chk("abort_no_we", we_seen, 0);
        chk("abort_still_done", {31'd0, done}, 32'd1);
        chk_run = 1'b1;

        // Reset in the middle of the HALT-word write.
        setup(16'h0, 16'h0, 16'h0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(mem_we && mem_addr == 9'd1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("wr1_reached", {31'd0, (mem_we && mem_addr == 9'd1)}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_wr1_we_hold", {30'd0, mem_we, cpu_hold}, 32'd1);
        chk("rst_wr1_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("rst_wr1_cleared", {27'd0, vec_idx, any_fail}, 32'd0);
        run_seq("after_rst", 16, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/proc_test_sequencer.md
Name: proc_test_sequencer

Overview:
Synthesizable, parametrised self-test sequencer for the single-core processor. It steps through a table of directed test vectors. For each vector it:
- writes the instruction word, followed by a HALT word, into processor RAM;
- restarts the processor by clearing PC, T and i;
- runs the processor until HALT or a timeout;
- reads back one architectural result (register, memory word, PC or LO) and compares it against the expected value.

It sits beside `proc` and `proc_ram` and owns the RAM write port and the processor hold/restart controls while busy.

Parameters:
- DATA_W, 32, width of data words, instruction words and expected values
- ADDR_W, 9, RAM address width
- NUM_TESTS, 16, number of vectors in the table (at least 1)
- IDX_W, 4, vector index width; equals $clog2(NUM_TESTS)
- TIMEOUT, 1024, maximum run cycles per vector before it is declared failed
- HALT_WORD, {5'd26,27'd0}, word written at address 1 after the test instruction

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-high reset
- start, in, 1, level-sampled start request
- abort, in, 1, synchronous abort of the sequence
- vec_idx, out, IDX_W, vector table index
- vec_instr, in, DATA_W, instruction for vec_idx; valid 1 cycle after vec_idx changes
- vec_sel, in, 2, check target: 0 = register, 1 = memory, 2 = PC, 3 = LO
- vec_addr, in, ADDR_W, register number (low 4 bits) or memory address
- vec_expected, in, DATA_W, expected value
- mem_we, out, 1, RAM write enable
- mem_addr, out, ADDR_W, RAM write address
- mem_wdata, out, DATA_W, RAM write data
- cpu_hold, out, 1, holds the processor idle (no T advance)
- cpu_restart, out, 1, one-cycle pulse clearing PC, T and i
- cpu_halted, in, 1, processor has executed HALT
- dbg_sel, out, 2, debug read select (same encoding as vec_sel)
- dbg_addr, out, ADDR_W, debug read address
- dbg_rdata, in, DATA_W, debug data; valid 1 cycle after dbg_sel/dbg_addr
- busy, out, 1, sequence in progress
- done, out, 1, sequence complete; stays high until the next start
- pass_count, out, IDX_W+1, number of vectors passed
- fail_count, out, IDX_W+1, number of vectors failed
- first_fail, out, IDX_W, index of the first failing vector
- any_fail, out, 1, at least one vector failed
- timeout_seen, out, 1, at least one vector timed out

Behaviour:
- Reset (asynchronous) values:
  - state IDLE;
  - all counters, indices, any_fail, timeout_seen, done, busy, mem_we, cpu_restart = 0;
  - cpu_hold = 1;
  - dbg_sel, dbg_addr, mem_addr, mem_wdata = 0.
- State machine:
  - IDLE: start=1 clears the counters, any_fail, timeout_seen and done; sets vec_idx=0 and busy=1; goes to FETCH.
  - FETCH: 1-cycle wait for table data; goes to WR0.
  - WR0: mem_we=1, mem_addr=0, mem_wdata=vec_instr; goes to WR1.
  - WR1: mem_we=1, mem_addr=1, mem_wdata=HALT_WORD; goes to RESTART.
  - RESTART: cpu_restart=1, cpu_hold=1; clears the cycle counter; goes to RUN.
  - RUN: cpu_hold=0; the cycle counter increments every cycle.
    - cpu_halted=1 takes priority: go to READ.
    - Otherwise, when counter == TIMEOUT-1: set timeout_seen, count a fail, go to NEXT.
  - READ: cpu_hold=1; dbg_sel=vec_sel, dbg_addr=vec_addr; goes to CMP.
  - CMP: dbg_rdata == vec_expected increments pass_count. A mismatch increments fail_count and sets any_fail; if any_fail was previously 0, first_fail is captured. Goes to NEXT.
  - NEXT: if vec_idx == NUM_TESTS-1, go to DONE_ST; otherwise increment vec_idx and go to FETCH.
  - DONE_ST: done=1, busy=0, cpu_hold=1; start=1 begins a new sequence, same as IDLE.
- A timeout is recorded as a fail and also updates first_fail.
- cpu_halted is ignored in every state except RUN. A stale halt from the previous vector is cleared by the restart pulse and must not be sampled in the RESTART cycle.
- abort=1 in any busy state leaves counts unchanged, drives mem_we=0 and cpu_hold=1, and goes to DONE_ST. abort has priority over all other transitions.
- start while busy is ignored.
- Outputs are registered. mem_we and cpu_restart are never both high in the same cycle.
- Invariant: pass_count + fail_count equals the number of vectors completed.
- Reset asserted mid-sequence returns immediately to the reset values.

Test Plan:
- Single vector {ld r1 ← mem[85]}, sel=0, addr=1, expected=426, RAM[85]=426 → writes to addr 0 and 1, halt within TIMEOUT, pass_count=1, fail_count=0, done=1.
- Four vectors (ADD expect 205, ADDI expect 112, MUL LO expect 10506, NEG expect 4294967193) with the third expected value wrong (10507) → pass_count=3, fail_count=1, first_fail=2, any_fail=1.
- Vector whose instruction branches to a non-HALT loop, TIMEOUT=64 → exactly 64 RUN cycles, timeout_seen=1, fail_count=1, the sequencer continues with the next vector.
- Two back-to-back vectors with cpu_halted held high from the first → the second vector still runs for at least 1 cycle after the restart pulse and is not falsely completed.
- abort asserted during RUN of vector 5 of 16 → done=1 on the next cycle, pass_count+fail_count=5, cpu_hold=1, no further mem_we.
- Reset asserted during WR1 → mem_we=0 and cpu_hold=1 immediately; after release, start reruns from vec_idx=0 with the counts cleared.
